// File: rtl/line_fill_scheduler_if.sv
// ============================================================================
// line_fill_scheduler_if : SDRAM read port + line-buffer write port bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface line_fill_scheduler_if #(
    parameter int ADDR_W = 24
);
    logic              SD_REQ;
    logic [ADDR_W-1:0] SD_ADDR;
    logic              SD_ACK;
    logic              SD_VALID;
    logic [15:0]       SD_DATA;
    logic              BUF_WRn;
    logic [15:0]       BUF_DATA;

    modport master (
        output SD_REQ, SD_ADDR, BUF_WRn, BUF_DATA,
        input  SD_ACK, SD_VALID, SD_DATA
    );

    modport slave (
        input  SD_REQ, SD_ADDR, BUF_WRn, BUF_DATA,
        output SD_ACK, SD_VALID, SD_DATA
    );
endinterface

`default_nettype wire

// File: rtl/line_fill_scheduler.sv
// ============================================================================
// line_fill_scheduler : SDRAM burst fetch into the dual-clock line buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module line_fill_scheduler #(
    parameter int WORDS_PER_LINE = 800,
    parameter int BURST          = 16,
    parameter int ADDR_W         = 24
) (
    input  wire logic              CLK,
    input  wire logic              RST,
    input  wire logic              START_LINE,
    input  wire logic [ADDR_W-1:0] LINE_ADDR,
    input  wire logic              HALF_DONE,
    line_fill_scheduler_if.master  bus,
    output logic                   BUSY,
    output logic                   LINE_DONE,
    output logic                   UNDERRUN
);

    localparam int c_cnt_w = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int c_rem_w = $clog2(WORDS_PER_LINE + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_addr, r_pend_addr;
    logic [c_rem_w-1:0]  r_remaining;
    logic [c_cnt_w-1:0]  r_word_cnt;
    logic [1:0]          r_free;
    logic                r_pending, r_buf_wrn, r_line_done, r_underrun;
    logic [15:0]         r_buf_data;

    logic                w_xfer_word, w_burst_end, w_start_now, w_start_defer;
    logic                w_apply_pend, w_line_end;
    logic [1:0]          w_free_next;
    logic [c_rem_w-1:0]  w_rem_after;
    logic [ADDR_W-1:0]   w_next_line_addr;

    assign w_xfer_word   = (r_state == S_XFER) && bus.SD_VALID;
    assign w_burst_end   = w_xfer_word && (r_word_cnt == c_cnt_w'(BURST - 1));
    assign w_start_now   = START_LINE && ((r_state == S_IDLE) || (r_state == S_WAIT) ||
                                          ((r_state == S_REQ) && !bus.SD_ACK));
    assign w_start_defer = START_LINE && ((r_state == S_XFER) ||
                                          ((r_state == S_REQ) && bus.SD_ACK));
    // A start arriving on the last word itself is taken straight into the new line
    assign w_apply_pend     = w_burst_end && (r_pending || w_start_defer);
    assign w_next_line_addr = w_start_defer ? LINE_ADDR : r_pend_addr;
    assign w_rem_after      = r_remaining - c_rem_w'(BURST);
    assign w_line_end       = w_burst_end && !w_apply_pend && (w_rem_after == '0);

    always_comb begin
        w_free_next = r_free;
        if (w_burst_end && !HALF_DONE) begin
            if (r_free != 2'd0) w_free_next = r_free - 2'd1;
        end else if (HALF_DONE && !w_burst_end && (r_free != 2'd2)) begin
            w_free_next = r_free + 2'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (START_LINE) w_state_next = S_REQ;
            S_REQ:  if (bus.SD_ACK) w_state_next = S_XFER;
            S_XFER: begin
                if (w_burst_end) begin
                    if (w_apply_pend)              w_state_next = S_REQ;
                    else if (w_line_end)           w_state_next = S_IDLE;
                    else if (w_free_next != 2'd0)  w_state_next = S_REQ;
                    else                           w_state_next = S_WAIT;
                end
            end
            S_WAIT: if (START_LINE || (r_free != 2'd0)) w_state_next = S_REQ;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr      <= '0;
            r_pend_addr <= '0;
            r_remaining <= '0;
            r_word_cnt  <= '0;
            r_free      <= 2'd2;
            r_pending   <= 1'b0;
            r_buf_wrn   <= 1'b1;
            r_buf_data  <= '0;
            r_line_done <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_buf_wrn   <= !w_xfer_word;
            r_line_done <= w_line_end;
            r_free      <= w_free_next;
            if (w_xfer_word) r_buf_data <= bus.SD_DATA;
            if (HALF_DONE && (r_free == 2'd2)) r_underrun <= 1'b1;

            if ((r_state == S_REQ) && bus.SD_ACK) r_word_cnt <= '0;
            else if (w_xfer_word) r_word_cnt <= w_burst_end ? '0 : r_word_cnt + c_cnt_w'(1);

            if (w_start_now) begin
                r_addr      <= LINE_ADDR;
                r_remaining <= c_rem_w'(WORDS_PER_LINE);
                r_free      <= 2'd2;
            end else if (w_apply_pend) begin
                r_addr      <= w_next_line_addr;
                r_remaining <= c_rem_w'(WORDS_PER_LINE);
                r_free      <= 2'd2;
                r_pending   <= 1'b0;
            end else if (w_burst_end) begin
                r_addr      <= r_addr + ADDR_W'(BURST);
                r_remaining <= w_rem_after;
            end

            if (w_start_defer && !w_burst_end) begin
                r_pending   <= 1'b1;
                r_pend_addr <= LINE_ADDR;
            end
        end
    end

    assign bus.SD_REQ   = (r_state == S_REQ);
    assign bus.SD_ADDR  = r_addr;
    assign bus.BUF_WRn  = r_buf_wrn;
    assign bus.BUF_DATA = r_buf_data;
    assign BUSY         = (r_state != S_IDLE);
    assign LINE_DONE    = r_line_done;
    assign UNDERRUN     = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_line_fill_scheduler.sv
// ============================================================================
// tb_line_fill_scheduler : directed checks of line_fill_scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_line_fill_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START_LINE = 1'b0;
    logic [23:0] LINE_ADDR = '0;
    logic        HALF_DONE = 1'b0;
    logic        BUSY, LINE_DONE, UNDERRUN;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;
    int req_cnt  = 0;
    int done_cnt = 0;

    line_fill_scheduler_if #(.ADDR_W(24)) bus ();

    line_fill_scheduler #(
        .WORDS_PER_LINE(800),
        .BURST(16),
        .ADDR_W(24)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .START_LINE(START_LINE),
        .LINE_ADDR(LINE_ADDR),
        .HALF_DONE(HALF_DONE),
        .bus(bus.master),
        .BUSY(BUSY),
        .LINE_DONE(LINE_DONE),
        .UNDERRUN(UNDERRUN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (bus.BUF_WRn === 1'b0) wr_cnt++;
        if (bus.SD_REQ === 1'b1 && bus.SD_ACK === 1'b1) req_cnt++;
        if (LINE_DONE === 1'b1) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before 2ms");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    task automatic wait_req(input string tag, input logic [23:0] exp_addr);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.SD_REQ === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_seen"}, {31'd0, ok}, 32'd1);
        check({tag, "_addr"}, {8'd0, bus.SD_ADDR}, {8'd0, exp_addr});
    endtask

    task automatic serve(input logic [15:0] base, input bit hd_last);
        bus.SD_ACK = 1'b1;
        tick();
        bus.SD_ACK = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.SD_VALID = 1'b1;
            bus.SD_DATA  = base + 16'(i);
            if (i == 15) HALF_DONE = hd_last;
            tick();
            bus.SD_VALID = 1'b0;
            HALF_DONE    = 1'b0;
        end
    endtask

    task automatic pulse_hd();
        HALF_DONE = 1'b1;
        tick();
        HALF_DONE = 1'b0;
    endtask

    task automatic pulse_start(input logic [23:0] addr);
        LINE_ADDR  = addr;
        START_LINE = 1'b1;
        tick();
        START_LINE = 1'b0;
    endtask

    initial begin
        int wr0, req0, done0;
        bus.SD_ACK   = 1'b0;
        bus.SD_VALID = 1'b0;
        bus.SD_DATA  = '0;

        // Reset state
        repeat (3) tick();
        check("rst_sd_req",    {31'd0, bus.SD_REQ},  32'd0);
        check("rst_sd_addr",   {8'd0, bus.SD_ADDR},  32'd0);
        check("rst_buf_wrn",   {31'd0, bus.BUF_WRn}, 32'd1);
        check("rst_buf_data",  {16'd0, bus.BUF_DATA}, 32'd0);
        check("rst_busy",      {31'd0, BUSY},        32'd0);
        check("rst_line_done", {31'd0, LINE_DONE},   32'd0);
        check("rst_underrun",  {31'd0, UNDERRUN},    32'd0);
        RST = 1'b0;
        tick();

        // First two bursts, then WAIT with both halves full
        pulse_start(24'h001000);
        check("start_busy", {31'd0, BUSY}, 32'd1);
        wait_req("req0", 24'h001000);
        serve(16'h1000, 1'b0);
        wait_req("req1", 24'h001010);
        serve(16'h1010, 1'b0);
        repeat (8) tick();
        check("wait_no_req", {31'd0, bus.SD_REQ}, 32'd0);
        check("wait_busy",   {31'd0, BUSY},       32'd1);

        // One credit back releases exactly one request, two cycles later
        pulse_hd();
        check("hd_req_early", {31'd0, bus.SD_REQ}, 32'd0);
        tick();
        check("hd_req",      {31'd0, bus.SD_REQ}, 32'd1);
        check("hd_req_addr", {8'd0, bus.SD_ADDR}, 32'h001020);
        bus.SD_ACK = 1'b1;
        tick();
        bus.SD_ACK = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.SD_VALID = 1'b1;
            bus.SD_DATA  = 16'hA000 + 16'(i);
            tick();
            bus.SD_VALID = 1'b0;
            check("wr_low",  {31'd0, bus.BUF_WRn},  32'd0);
            check("wr_data", {16'd0, bus.BUF_DATA}, 32'hA000 + i);
            tick();
            check("wr_high", {31'd0, bus.BUF_WRn},  32'd1);
        end
        repeat (4) tick();
        check("third_wait", {31'd0, bus.SD_REQ}, 32'd0);

        // Whole line with a credit returned after every burst
        wr0 = wr_cnt; req0 = req_cnt; done0 = done_cnt;
        pulse_start(24'h001000);
        for (int k = 0; k < 50; k++) begin
            wait_req("line_req", 24'h001000 + 24'(16 * k));
            serve(16'(k * 16), 1'b0);
            pulse_hd();
        end
        repeat (2) tick();
        check("line_done_cnt", done_cnt - done0, 32'd1);
        check("line_writes",   wr_cnt - wr0,     32'd800);
        check("line_reqs",     req_cnt - req0,   32'd50);
        check("line_busy",     {31'd0, BUSY},    32'd0);
        check("line_no_under", {31'd0, UNDERRUN}, 32'd0);

        // Credit on the last word keeps free_halves at one
        pulse_start(24'h300000);
        wait_req("c_req0", 24'h300000);
        serve(16'h0, 1'b0);
        wait_req("c_req1", 24'h300010);
        serve(16'h0, 1'b1);
        check("coinc_req",  {31'd0, bus.SD_REQ}, 32'd1);
        check("coinc_addr", {8'd0, bus.SD_ADDR}, 32'h300020);
        serve(16'h0, 1'b0);
        repeat (5) tick();
        check("coinc_wait", {31'd0, bus.SD_REQ}, 32'd0);

        // Underrun: third credit with both halves already free
        pulse_hd();
        tick();
        pulse_hd();
        check("under_before", {31'd0, UNDERRUN}, 32'd0);
        pulse_hd();
        check("under_set", {31'd0, UNDERRUN}, 32'd1);
        repeat (5) tick();
        check("under_sticky",  {31'd0, UNDERRUN},  32'd1);
        check("req_hold",      {31'd0, bus.SD_REQ}, 32'd1);
        check("req_hold_addr", {8'd0, bus.SD_ADDR}, 32'h300030);

        // START_LINE mid-burst after 7 words
        wr0 = wr_cnt; done0 = done_cnt;
        bus.SD_ACK = 1'b1;
        tick();
        bus.SD_ACK = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) pulse_start(24'h200000);
            bus.SD_VALID = 1'b1;
            bus.SD_DATA  = 16'hB000 + 16'(i);
            tick();
            bus.SD_VALID = 1'b0;
        end
        check("mid_req",  {31'd0, bus.SD_REQ}, 32'd1);
        check("mid_addr", {8'd0, bus.SD_ADDR}, 32'h200000);
        repeat (2) tick();
        check("mid_writes",  wr_cnt - wr0,     32'd16);
        check("mid_no_done", done_cnt - done0, 32'd0);
        check("mid_last_data", {16'd0, bus.BUF_DATA}, 32'h0000B00F);

        // Reset in the middle of a burst
        bus.SD_ACK = 1'b1;
        tick();
        bus.SD_ACK = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.SD_VALID = 1'b1;
            bus.SD_DATA  = 16'hC000 + 16'(i);
            tick();
        end
        bus.SD_VALID = 1'b0;
        check("pre_rst_wrn", {31'd0, bus.BUF_WRn}, 32'd0);
        RST = 1'b1;
        #1;
        check("arst_sd_req",    {31'd0, bus.SD_REQ},   32'd0);
        check("arst_sd_addr",   {8'd0, bus.SD_ADDR},   32'd0);
        check("arst_buf_wrn",   {31'd0, bus.BUF_WRn},  32'd1);
        check("arst_buf_data",  {16'd0, bus.BUF_DATA}, 32'd0);
        check("arst_busy",      {31'd0, BUSY},         32'd0);
        check("arst_line_done", {31'd0, LINE_DONE},    32'd0);
        check("arst_underrun",  {31'd0, UNDERRUN},     32'd0);
        tick();
        RST = 1'b0;
        tick();
        wr0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            bus.SD_VALID = 1'b1;
            bus.SD_DATA  = 16'hD000 + 16'(i);
            tick();
        end
        bus.SD_VALID = 1'b0;
        repeat (2) tick();
        check("post_rst_writes", wr_cnt - wr0, 32'd0);
        check("post_rst_wrn",  {31'd0, bus.BUF_WRn}, 32'd1);
        check("post_rst_busy", {31'd0, BUSY},        32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/line_fill_scheduler.md
Name: line_fill_scheduler

Overview:
- Sequences the 32x16 dual-clock line buffer from the SDRAM clock domain.
- Issues 16-word SDRAM burst reads for one video line and writes the returned words into the buffer through its write port (WRn, DATA_WR).
- Keeps at most two half-buffers (2x16 words) ahead of the video reader, using "half consumed" credits returned from the video side.
- Sits between the SDRAM controller read port and the write side of the line buffer.

Parameters:
- WORDS_PER_LINE, 800, words fetched per line; must be a nonzero multiple of 2*BURST so the buffer's free-running pointers realign every line.
- BURST, 16, words per SDRAM burst; equals half the buffer depth.
- ADDR_W, 24, SDRAM word-address width.

Ports:
- CLK  in  1  SDRAM-domain clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- START_LINE  in  1  one-cycle pulse, already synchronized to CLK: begin fetching a line.
- LINE_ADDR  in  ADDR_W  first word address of the line; sampled when START_LINE is applied.
- HALF_DONE  in  1  one-cycle pulse, already synchronized: video side has consumed BURST words.
- SD_REQ  out  1  burst read request.
- SD_ADDR  out  ADDR_W  burst start address.
- SD_ACK  in  1  SDRAM controller accepted the request.
- SD_VALID  in  1  read data word valid.
- SD_DATA  in  16  read data word.
- BUF_WRn  out  1  active-low write strobe to the line buffer.
- BUF_DATA  out  16  write data to the line buffer.
- BUSY  out  1  high in any state other than IDLE.
- LINE_DONE  out  1  one-cycle pulse when the last burst of a line completes.
- UNDERRUN  out  1  sticky flag: HALF_DONE received while no half-buffer was filled.

Behaviour:
- Reset values: SD_REQ=0, SD_ADDR=0, BUF_WRn=1, BUF_DATA=0, BUSY=0, LINE_DONE=0, UNDERRUN=0.
- Reset internals: state=IDLE, free_halves=2, remaining=0, pending=0.
- Reset mid-burst abandons the burst. Any SD_VALID arriving after reset is ignored.
- States: IDLE, REQ, XFER, WAIT.
- Applying START_LINE: addr<=LINE_ADDR, remaining<=WORDS_PER_LINE, free_halves<=2, state<=REQ.
  - Applied immediately in IDLE, WAIT, or REQ without SD_ACK.
  - In XFER, or in REQ with SD_ACK in the same cycle, the burst completes first. START_LINE and LINE_ADDR are latched into pending and applied in the cycle after the burst's last word; this replaces the normal post-burst transition and suppresses LINE_DONE.
- REQ: SD_REQ=1, SD_ADDR=addr, both held stable until SD_ACK. On SD_ACK: SD_REQ<=0, word count<=0, state<=XFER.
- XFER, per SD_VALID cycle:
  - BUF_DATA<=SD_DATA, BUF_WRn<=0 for exactly one cycle (registered, one-cycle latency). Otherwise BUF_WRn=1.
  - Word count increments.
  - SD_VALID in any other state is ignored and produces no buffer write.
- On the BURST-th word:
  - addr<=addr+BURST, with wrap modulo 2^ADDR_W.
  - remaining<=remaining-BURST; free_halves decrements.
  - Next state: remaining==0 goes to IDLE with LINE_DONE=1 for one cycle. Otherwise free_halves>0 goes to REQ, else WAIT.
- WAIT: go to REQ in the cycle after free_halves becomes nonzero.
- HALF_DONE: free_halves increments, saturating at 2.
  - HALF_DONE arriving when free_halves==2 sets UNDERRUN (cleared only by RST).
  - HALF_DONE in the same cycle as a burst-completion decrement leaves free_halves unchanged.
  - In IDLE, HALF_DONE only updates free_halves (saturating).
- Every line writes a multiple of 32 words, so the buffer's write pointer returns to 0 at each line end.
- No request is issued while free_halves==0.
- Gap between SD_ACK and first SD_VALID is unbounded; gaps between SD_VALID words are allowed.

Test Plan:
- Reset, then START_LINE with LINE_ADDR=0x001000 → SD_REQ with SD_ADDR=0x001000; after ACK plus 16 valid words, a second request at 0x001010, then WAIT (no third request).
- In WAIT, pulse HALF_DONE → SD_REQ within 2 cycles at 0x001020; 16 SD_VALID words 0xA000..0xA00F → 16 single-cycle BUF_WRn lows, each carrying BUF_DATA equal to the SD_DATA word from the prior cycle.
- Full line with HALF_DONE pulsed after every burst → 50 requests at addresses 0x001000+16k, then LINE_DONE for exactly one cycle, BUSY=0, and 800 buffer writes in total.
- HALF_DONE coincident with the 16th SD_VALID of a burst → free_halves unchanged and the next request issued immediately. HALF_DONE with free_halves==2 → UNDERRUN=1 until RST.
- START_LINE (LINE_ADDR=0x200000) mid-XFER at word 7 → remaining 9 words still written, no LINE_DONE, next request at 0x200000. RST asserted mid-burst → all outputs at reset values in the same cycle, and later SD_VALID causes no writes.
